// File: rtl/overlay_plotter.sv
// Scans a snapshotted 1-bpp overlay bitmap out as row-major VGA pixel writes.
// Optional OVERLAY_TRANSPARENT_EN: clear bits suppress plot so the board shows through.
module overlay_plotter #(
  parameter int W        = 100,
  parameter int H        = 100,
  parameter int X_OFFSET = 30,
  parameter int Y_OFFSET = 10,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [W*H-1:0]  bitmap,
  input  logic [CW-1:0]   fg_colour,
  input  logic [CW-1:0]   bg_colour,
  output logic [XW-1:0]   x,
  output logic [YW-1:0]   y,
  output logic [CW-1:0]   colour,
  output logic            plot,
  output logic            busy,
  output logic            done
);

  localparam int N   = W * H;
  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int CYW = (H > 1) ? $clog2(H) : 1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    snap_q, snap_d;
  logic [CW-1:0]   fg_q, fg_d, bg_q, bg_d;
  logic [CXW-1:0]  c_q, c_d;
  logic [CYW-1:0]  r_q, r_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IW-1:0]   idx;
  logic            pix;

  // Row MSB is the leftmost pixel, so the bit index runs down within a row.
  assign idx = IW'(32'(r_q) * 32'(W) + 32'(W - 1) - 32'(c_q));
  assign pix = snap_q[idx];

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    c_d      = c_q;
    r_d      = r_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Outputs lag state by one edge; done_q marks the visible DONE cycle,
        // where a start request must still be ignored.
        if (start && !done_q) begin
          snap_d  = bitmap;
          fg_d    = fg_colour;
          bg_d    = bg_colour;
          c_d     = '0;
          r_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        x_d      = XW'(32'(X_OFFSET) + 32'(c_q));
        y_d      = YW'(32'(Y_OFFSET) + 32'(r_q));
        colour_d = pix ? fg_q : bg_q;
`ifdef OVERLAY_TRANSPARENT_EN
        plot_d   = pix;
`else
        plot_d   = 1'b1;
`endif
        busy_d   = 1'b1;
        if (c_q == CXW'(W - 1)) begin
          c_d = '0;
          if (r_q == CYW'(H - 1)) begin
            state_d = DONE;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      c_q      <= '0;
      r_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      c_q      <= c_d;
      r_q      <= r_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_overlay_plotter.sv
// Directed bench for overlay_plotter at default geometry (100x100 at 30,10).
module tb_overlay_plotter;

  localparam int W = 100;
  localparam int H = 100;
  localparam int N = W * H;
`ifdef OVERLAY_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   bitmap;
  logic [2:0]     fg_colour, bg_colour;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  overlay_plotter #(
    .W(W), .H(H), .X_OFFSET(30), .Y_OFFSET(10), .XW(8), .YW(7), .CW(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bitmap(bitmap),
    .fg_colour(fg_colour), .bg_colour(bg_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Starts a draw and follows it to the end, checking every pixel against img.
  // tamper: zero the bitmap and pulse start mid-scan, and pulse start in the done cycle.
  task automatic scan(input logic [N-1:0] img, input logic [2:0] f, input logic [2:0] b,
                      input bit tamper, output logic [2:0] col1, output logic [2:0] coln,
                      output logic plot2);
    int bad = 0, plots = 0, expplots = 0, c, r;
    logic pix, ep;
    @(negedge clock);
    bitmap = img; fg_colour = f; bg_colour = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      @(posedge clock);
      #1;
      c   = (k - 1) % W;
      r   = (k - 1) / W;
      pix = img[r * W + (W - 1 - c)];
      ep  = TRANSP ? pix : 1'b1;
      if (x !== 8'(30 + c) || y !== 7'(10 + r) || plot !== ep || busy !== 1'b1 || done !== 1'b0)
        bad++;
      if (pix && colour !== f) bad++;
      if (!pix && !TRANSP && colour !== b) bad++;
      if (plot === 1'b1) plots++;
      if (ep) expplots++;
      if (k == 1) begin
        check("first_x", 32'(x), 30);
        check("first_y", 32'(y), 10);
        col1 = colour;
      end
      if (k == 2) plot2 = plot;
      if (k == W) check("row0_end_x", 32'(x), 129);
      if (k == W + 1) begin
        check("row1_x", 32'(x), 30);
        check("row1_y", 32'(y), 11);
      end
      if (k == N) begin
        check("last_x", 32'(x), 129);
        check("last_y", 32'(y), 109);
        coln = colour;
      end
      if (tamper && k == 500) begin bitmap = '0; start = 1'b1; end
      if (tamper && k == 501) start = 1'b0;
    end
    @(posedge clock);
    #1;
    check("done_pulse", 32'(done), 1);
    check("done_plot", 32'(plot), 0);
    check("done_busy", 32'(busy), 0);
    if (tamper) start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check("done_once", 32'(done), 0);
    @(posedge clock);
    #1;
    check("no_restart", 32'({plot, busy}), 0);
    check("pixels", 32'(bad), 0);
    check("plot_count", 32'(plots), 32'(expplots));
  endtask

  initial begin
    logic [N-1:0] img;
    logic [2:0]   c1, cn;
    logic         p2;
    int           seen;

    reset = 1'b1; start = 1'b0; bitmap = '0; fg_colour = '0; bg_colour = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1 check("idle_outputs", 32'({x, y, colour, plot, busy, done}), 0);
    end

    // All ones, fg=7 bg=0
    img = '1;
    scan(img, 3'b111, 3'b000, 1'b0, c1, cn, p2);
    check("ones_first_colour", 32'(c1), 7);
    check("ones_last_colour", 32'(cn), 7);

    // Corner bits only, with mid-scan bitmap change and ignored start pulses
    img = '0;
    img[99] = 1'b1;
    img[9900] = 1'b1;
    scan(img, 3'b100, 3'b001, 1'b1, c1, cn, p2);
    check("corner_top_left", 32'(c1), 4);
    check("corner_bot_right", 32'(cn), 4);
    check("clear_pixel_plot", 32'(p2), 32'(!TRANSP));

    // Reset sampled at T+2000
    @(negedge clock);
    bitmap = '1; fg_colour = 3'b010; bg_colour = 3'b000; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (1999) @(posedge clock);
    #1 check("pre_reset_plot", 32'(plot), 1);
    reset = 1'b1;
    @(posedge clock);
    #1 check("reset_mid_scan", 32'({plot, busy}), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8200; i++) begin
      @(posedge clock);
      #1 if (done || plot || busy) seen++;
    end
    check("silent_after_reset", 32'(seen), 0);

    // Checkerboard: pixel (c,r) set when c+r is even
    img = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (((c + r) % 2) == 0) img[r * W + (W - 1 - c)] = 1'b1;
    scan(img, 3'b110, 3'b011, 1'b0, c1, cn, p2);
    check("checker_first", 32'(c1), 6);
    check("checker_last", 32'(cn), 6);
    check("checker_second_plot", 32'(p2), 32'(!TRANSP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
